modex_processor: RTL and testbench

//   RSA decryption engine. Holds a ROM of 2**ADDR encrypted ARQ-bit words.

---
 rtl/modex_processor.sv | 143 ++++++++++++++
 tb/tb_modex_processor.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/modex_processor.sv
// RSA decryption engine: a ciphertext ROM word is raised to KEY_D modulo KEY_N by
// left-to-right square-and-multiply, one exponent bit per clock.
module modex_processor #(
    parameter int               ADDR  = 10,
    parameter int               ARQ   = 16,
    parameter int               EXP_W = 12,
    parameter logic [ARQ-1:0]   KEY_N = 16'd3233,
    parameter logic [EXP_W-1:0] KEY_D = 12'd2753
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ADDR-1:0] address,
    output logic [ARQ-1:0]  encripted,
    output logic [ARQ-1:0]  desencripted
);

    localparam int               IDX_W    = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [2*ARQ-1:0] MOD_WIDE = {{ARQ{1'b0}}, KEY_N};
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(EXP_W - 1);
    localparam logic [EXP_W-1:0] KEY_BITS = KEY_D;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EXP  = 2'd2,
        DONE = 2'd3
    } ModexState;

    ModexState        r_state;
    ModexState        w_stateNext;
    logic [ADDR-1:0]  r_addr;
    logic             r_first;
    logic [ARQ-1:0]   r_acc;
    logic [ARQ-1:0]   r_base;
    logic [IDX_W-1:0] r_bitIdx;

    logic [ARQ-1:0]   w_romWord;
    logic [ARQ-1:0]   w_base;
    logic [2*ARQ-1:0] w_sqFull;
    logic [ARQ-1:0]   w_sq;
    logic [2*ARQ-1:0] w_mulFull;
    logic [ARQ-1:0]   w_mul;
    logic [ARQ-1:0]   w_accNext;
    logic             w_keyBit;
    logic             w_lastBit;
    logic             w_start;

    // Ciphertext image: four fixed words plus a deterministic hash fill that also
    // produces words above the modulus, so the base reduction path is exercised.
    function automatic logic [ARQ-1:0] romWord(input logic [ADDR-1:0] a);
        logic [31:0] hashVal;
        hashVal = 32'(a) * 32'd40503 + 32'd12345;
        case (a)
            ADDR'(0): romWord = ARQ'(2790);
            ADDR'(1): romWord = ARQ'(0);
            ADDR'(2): romWord = ARQ'(1);
            ADDR'(3): romWord = ARQ'(3233);
            default:  romWord = ARQ'(hashVal);
        endcase
    endfunction

    assign w_romWord = romWord(r_addr);
    assign w_base    = ARQ'({{ARQ{1'b0}}, w_romWord} % MOD_WIDE);

    // Full double-width products are reduced before any truncation.
    assign w_sqFull  = {{ARQ{1'b0}}, r_acc} * {{ARQ{1'b0}}, r_acc};
    assign w_sq      = ARQ'(w_sqFull % MOD_WIDE);
    assign w_mulFull = {{ARQ{1'b0}}, w_sq} * {{ARQ{1'b0}}, r_base};
    assign w_mul     = ARQ'(w_mulFull % MOD_WIDE);

    assign w_keyBit  = KEY_BITS[r_bitIdx];
    assign w_accNext = w_keyBit ? w_mul : w_sq;
    assign w_lastBit = (r_bitIdx == '0);
    assign w_start   = r_first || (address != r_addr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_stateNext = LOAD;
                end
            end
            LOAD: w_stateNext = EXP;
            EXP: begin
                if (w_lastBit) begin
                    w_stateNext = DONE;
                end
            end
            DONE:    w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // The address is only sampled in IDLE; changes during a run wait for the next IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr       <= '0;
            r_first      <= 1'b1;
            r_acc        <= '0;
            r_base       <= '0;
            r_bitIdx     <= '0;
            encripted    <= '0;
            desencripted <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_addr  <= address;
                        r_first <= 1'b0;
                    end
                end
                LOAD: begin
                    encripted <= w_romWord;
                    r_base    <= w_base;
                    r_acc     <= ARQ'(1);
                    r_bitIdx  <= IDX_TOP;
                end
                EXP: begin
                    r_acc <= w_accNext;
                    if (!w_lastBit) begin
                        r_bitIdx <= r_bitIdx - 1'b1;
                    end
                end
                DONE: begin
                    desencripted <= r_acc;
                end
                default: begin
                    r_acc <= r_acc;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modex_processor.sv
// Self-checking bench for modex_processor: fixed vectors, corner sequences, a full
// address sweep and randomized address changes against a repeated-multiply model.
module tb_modex_processor;

    localparam int unsigned N_MOD = 3233;
    localparam int unsigned D_EXP = 2753;

    typedef struct {
        logic [9:0]  addr;
        logic [15:0] expEnc;
        logic [15:0] expDec;
    } VecT;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  address = '0;
    logic [15:0] encripted;
    logic [15:0] desencripted;

    int          checkCount = 0;
    int          passCount  = 0;
    int unsigned romModel[1024];
    int unsigned decModel[1024];
    int unsigned lastAddr;
    VecT         vecs[6];

    modex_processor #(
        .ADDR(10),
        .ARQ(16),
        .EXP_W(12),
        .KEY_N(16'd3233),
        .KEY_D(12'd2753)
    ) dut (
        .clk(clk),
        .rst(rst),
        .address(address),
        .encripted(encripted),
        .desencripted(desencripted)
    );

    always #5 clk = ~clk;

    function automatic int unsigned romImage(int unsigned a);
        case (a)
            0:       return 2790;
            1:       return 0;
            2:       return 1;
            3:       return 3233;
            default: return (a * 40503 + 12345) & 32'h0000_FFFF;
        endcase
    endfunction

    // Plain c^d mod n by d successive multiplications.
    function automatic int unsigned powMod(int unsigned c, int unsigned d, int unsigned n);
        int unsigned b;
        int unsigned r;
        b = c % n;
        r = 1 % n;
        for (int k = 0; k < int'(d); k++) begin
            r = (r * b) % n;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input int unsigned expected);
        checkCount++;
        if (actual == 16'(expected)) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic stepEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [9:0] a);
        @(negedge clk);
        address = a;
    endtask

    task automatic runAddr(input int unsigned a);
        applyStimulus(10'(a));
        stepEdges(15);
        checkOutput("sweepEnc", encripted, romModel[a]);
        checkOutput("sweepDec", desencripted, decModel[a]);
        lastAddr = a;
    endtask

    initial begin
        int unsigned a;
        int unsigned b;
        int          k;

        for (int i = 0; i < 1024; i++) begin
            romModel[i] = romImage(i);
            decModel[i] = powMod(romModel[i], D_EXP, N_MOD);
        end

        vecs[0] = '{addr: 10'd1,   expEnc: 16'd0,    expDec: 16'd0};
        vecs[1] = '{addr: 10'd2,   expEnc: 16'd1,    expDec: 16'd1};
        vecs[2] = '{addr: 10'd3,   expEnc: 16'd3233, expDec: 16'd0};
        vecs[3] = '{addr: 10'd0,   expEnc: 16'd2790, expDec: 16'd65};
        vecs[4] = '{addr: 10'd4,   expEnc: 16'(romModel[4]),   expDec: 16'(decModel[4])};
        vecs[5] = '{addr: 10'd777, expEnc: 16'(romModel[777]), expDec: 16'(decModel[777])};

        // Reset state, then forced start on address 0 after release.
        rst = 1'b0;
        address = '0;
        stepEdges(3);
        checkOutput("resetEnc", encripted, 0);
        checkOutput("resetDec", desencripted, 0);
        @(negedge clk);
        rst = 1'b1;
        stepEdges(14);
        checkOutput("firstEncLoaded", encripted, 2790);
        checkOutput("firstDecNotYet", desencripted, 0);
        stepEdges(1);
        checkOutput("firstDec", desencripted, 65);
        lastAddr = 0;

        $display("[TB] table vectors");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].addr);
            stepEdges(15);
            checkOutput("tableEnc", encripted, vecs[i].expEnc);
            checkOutput("tableDec", desencripted, vecs[i].expDec);
            lastAddr = vecs[i].addr;
        end

        // Address change mid-run: old request finishes first, new one follows.
        $display("[TB] mid-run address change");
        applyStimulus(10'd1);
        stepEdges(4);
        applyStimulus(10'd2);
        stepEdges(11);
        checkOutput("changeFirstEnc", encripted, 0);
        checkOutput("changeFirstDec", desencripted, 0);
        stepEdges(14);
        checkOutput("changeHoldDec", desencripted, 0);
        stepEdges(1);
        checkOutput("changeSecondEnc", encripted, 1);
        checkOutput("changeSecondDec", desencripted, 1);

        // Reset during EXP clears outputs at once; a fresh run follows release.
        $display("[TB] reset mid-run");
        applyStimulus(10'd0);
        stepEdges(6);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("abortEnc", encripted, 0);
        checkOutput("abortDec", desencripted, 0);
        @(negedge clk);
        rst = 1'b1;
        stepEdges(14);
        checkOutput("restartDecNotYet", desencripted, 0);
        stepEdges(1);
        checkOutput("restartEnc", encripted, 2790);
        checkOutput("restartDec", desencripted, 65);
        lastAddr = 0;

        $display("[TB] address sweep");
        for (int i = 1; i < 1024; i++) begin
            runAddr(i);
        end
        runAddr(0);

        $display("[TB] random address changes");
        for (int i = 0; i < 20; i++) begin
            a = $urandom_range(0, 1023);
            if (a == lastAddr) begin
                a = (a + 1) % 1024;
            end
            b = $urandom_range(0, 1023);
            k = int'($urandom_range(1, 13));
            applyStimulus(10'(a));
            stepEdges(k);
            applyStimulus(10'(b));
            stepEdges(15 - k);
            checkOutput("randFirstEnc", encripted, romModel[a]);
            checkOutput("randFirstDec", desencripted, decModel[a]);
            if (b != a) begin
                stepEdges(15);
                checkOutput("randSecondEnc", encripted, romModel[b]);
                checkOutput("randSecondDec", desencripted, decModel[b]);
            end
            lastAddr = b;
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
